// File: rtl/cvp14_pkg.sv
// Shared CVP14 definitions used by the vector load/store path.
//   - Opcode encodings for VLD and VST.
//   - Vector geometry: VEC_W bits made of NUM_ELEMS elements of ELEM_W bits.
//   - ldst_state_t: sequencer states of vector_ldst_unit.
//   - elem_lsb(): bit offset of element i inside a packed vector.
package cvp14_pkg;

    localparam logic [3:0] VLD = 4'b0100;
    localparam logic [3:0] VST = 4'b0101;

    localparam int VEC_W     = 256;
    localparam int ELEM_W    = 16;
    localparam int NUM_ELEMS = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        LD_LAST = 3'd2,
        STORE   = 3'd3,
        DONE    = 3'd4
    } ldst_state_t;

    // Element i lives at bits [ELEM_W*i + ELEM_W-1 : ELEM_W*i].
    function automatic int elem_lsb(input int i);
        return i * ELEM_W;
    endfunction

endpackage

// File: rtl/ldst_addr_gen.sv
// Element index counter and word address generator for vector transfers.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   load      - capture base_in, restart at element 0 (addr = base_in)
//   step      - advance to the next element (idx wraps to 0 after the last)
//   base_in   - starting word address
//   idx       - current element index
//   addr      - registered base + idx, modulo 2^ADDR_W
//   last      - idx is the final element of the transfer
module ldst_addr_gen #(
    parameter int NUM_ELEMS = 16,
    parameter int ADDR_W    = 16,
    localparam int IDX_W    = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_in,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  idx_nxt;

    assign last    = (idx == IDX_W'(NUM_ELEMS - 1));
    assign idx_nxt = last ? '0 : idx + 1'b1;

    // The address is registered one step ahead of use so the RAM address
    // presented in the cycle of element idx is already base + idx.
    // The ADDR_W-bit adder drops the carry, giving the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
            idx    <= '0;
            addr   <= '0;
        end else if (load) begin
            base_q <= base_in;
            idx    <= '0;
            addr   <= base_in;
        end else if (step) begin
            idx    <= idx_nxt;
            addr   <= base_q + ADDR_W'(idx_nxt);
        end
    end

endmodule

// File: rtl/vector_ldst_unit.sv
// Multi-cycle sequencer for VLD / VST between decode and the data RAM.
//   VLD: reads NUM_ELEMS consecutive words starting at base_addr and writes
//        the assembled vector to vector register vdst.
//   VST: writes the NUM_ELEMS elements of st_data to consecutive words.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   start, is_store, base_addr, vdst, st_data
//                     - request from decode, sampled only in IDLE
//   mem_addr, mem_rd, mem_wr, mem_wdata, mem_rdata
//                     - RAM interface; mem_rdata valid one cycle after mem_rd
//   vrf_wr_en, vrf_wr_dst, vrf_wr_data
//                     - vector register file write port (loads only)
//   busy              - high whenever not IDLE; decode stalls on it
//   done              - one-cycle completion pulse
// Every output is a register.
module vector_ldst_unit #(
    parameter int NUM_ELEMS = 16,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    localparam int IDX_W    = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        is_store,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [2:0]                  vdst,
    input  logic [NUM_ELEMS*DATA_W-1:0] st_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_rd,
    output logic                        mem_wr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        vrf_wr_en,
    output logic [2:0]                  vrf_wr_dst,
    output logic [NUM_ELEMS*DATA_W-1:0] vrf_wr_data,
    output logic                        busy,
    output logic                        done
);

    import cvp14_pkg::*;

    ldst_state_t                      state;
    logic [NUM_ELEMS-1:0][DATA_W-1:0] st_q;
    logic [NUM_ELEMS-1:0][DATA_W-1:0] vec_q;
    logic [2:0]                       vdst_q;

    logic [IDX_W-1:0] idx;
    logic             last;
    logic             gen_load;
    logic             gen_step;

    assign gen_load = (state == IDLE) && start;
    assign gen_step = (state == LOAD) || (state == STORE);

    ldst_addr_gen #(
        .NUM_ELEMS (NUM_ELEMS),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (gen_load),
        .step    (gen_step),
        .base_in (base_addr),
        .idx     (idx),
        .addr    (mem_addr),
        .last    (last)
    );

    // The assembly register doubles as the write-data output so the last
    // loaded vector stays visible between operations.
    assign vrf_wr_data = vec_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            st_q       <= '0;
            vec_q      <= '0;
            vdst_q     <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
            vrf_wr_en  <= 1'b0;
            vrf_wr_dst <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done      <= 1'b0;
            vrf_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vdst_q <= vdst;
                        st_q   <= st_data;
                        busy   <= 1'b1;
                        if (is_store) begin
                            state     <= STORE;
                            mem_wr    <= 1'b1;
                            mem_wdata <= st_data[DATA_W-1:0];
                        end else begin
                            state  <= LOAD;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // Read data trails the read strobe by one cycle, so this
                    // cycle's mem_rdata belongs to the previous element.
                    if (idx != '0)
                        vec_q[idx - 1'b1] <= mem_rdata;
                    if (last) begin
                        state  <= LD_LAST;
                        mem_rd <= 1'b0;
                    end
                end
                LD_LAST: begin
                    vec_q[NUM_ELEMS-1] <= mem_rdata;
                    state      <= DONE;
                    done       <= 1'b1;
                    vrf_wr_en  <= 1'b1;
                    vrf_wr_dst <= vdst_q;
                end
                STORE: begin
                    if (last) begin
                        state     <= DONE;
                        mem_wr    <= 1'b0;
                        mem_wdata <= '0;
                        done      <= 1'b1;
                    end else begin
                        // Data is staged one element ahead, like the address.
                        mem_wdata <= st_q[idx + 1'b1];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_ldst_unit.sv
module tb_vector_ldst_unit;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         is_store = 1'b0;
    logic [15:0]  base_addr = '0;
    logic [2:0]   vdst = '0;
    logic [255:0] st_data = '0;
    logic [15:0]  mem_addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata = '0;
    logic         vrf_wr_en;
    logic [2:0]   vrf_wr_dst;
    logic [255:0] vrf_wr_data;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    vector_ldst_unit #(.NUM_ELEMS(16), .DATA_W(16), .ADDR_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_store    (is_store),
        .base_addr   (base_addr),
        .vdst        (vdst),
        .st_data     (st_data),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .vrf_wr_en   (vrf_wr_en),
        .vrf_wr_dst  (vrf_wr_dst),
        .vrf_wr_data (vrf_wr_data),
        .busy        (busy),
        .done        (done)
    );

    // RAM model: one-cycle read latency, plus a backdoor port for preloading.
    logic [15:0] ram [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (mem_wr)      ram[mem_addr] <= mem_wdata;
        else if (pre_we) ram[pre_addr] <= pre_data;
        if (mem_rd)      mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic         st;
        logic [15:0]  base;
        logic [2:0]   vdst;
        logic [255:0] data;   // store data, or RAM contents for a load
        int           lat;    // cycle of the done pulse after the start edge
    } vec_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        logic [2:0]   dst;
        logic [255:0] data;
    } vrf_t;

    acc_t acc_q[$];
    vrf_t vrf_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every RAM strobe and every register-file write must match
    // the next expectation queued when the operation was launched.
    acc_t mon_a;
    vrf_t mon_v;
    always @(negedge clk) begin
        if (rst) begin
            if (mem_rd && mem_wr)
                chk("rd_wr_overlap", 256'({mem_rd, mem_wr}), 256'(0));
            if (mem_rd || mem_wr) begin
                if (acc_q.size() == 0) begin
                    chk("extra_access", 256'({mem_rd, mem_wr}), 256'(0));
                end else begin
                    mon_a = acc_q.pop_front();
                    chk("acc_kind", 256'(mem_wr), 256'(mon_a.wr));
                    chk("acc_addr", 256'(mem_addr), 256'(mon_a.addr));
                    if (mon_a.wr) chk("acc_wdata", 256'(mem_wdata), 256'(mon_a.wdata));
                end
            end
            if (vrf_wr_en) begin
                if (vrf_q.size() == 0) begin
                    chk("extra_vrf_wr", 256'(vrf_wr_en), 256'(0));
                end else begin
                    mon_v = vrf_q.pop_front();
                    chk("vrf_dst", 256'(vrf_wr_dst), 256'(mon_v.dst));
                    chk("vrf_data", vrf_wr_data, mon_v.data);
                end
            end
        end
    end

    task automatic preload(input logic [15:0] base, input logic [255:0] d);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_addr = base + 16'(i);
            pre_data = d[16*i +: 16];
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    function automatic logic [255:0] read_vec(input logic [15:0] base);
        logic [255:0] d;
        logic [15:0]  a;
        for (int i = 0; i < 16; i++) begin
            a = base + 16'(i);
            d[16*i +: 16] = ram[a];
        end
        return d;
    endfunction

    // Launch one transfer and follow it to done. inject>0 pulses a stray
    // start in that cycle; chain=1 returns right at the done cycle so the
    // caller can start again in the very next cycle.
    task automatic run_op(input vec_t v, input int inject, input bit chain);
        logic [15:0] ad;
        int          got;
        bit          busy_ok;
        if (!v.st) preload(v.base, v.data);
        for (int i = 0; i < 16; i++) begin
            ad = v.base + 16'(i);
            acc_q.push_back('{v.st, ad, v.st ? v.data[16*i +: 16] : 16'h0});
        end
        if (!v.st) vrf_q.push_back('{v.vdst, v.data});
        @(posedge clk); #1;
        start     = 1'b1;
        is_store  = v.st;
        base_addr = v.base;
        vdst      = v.vdst;
        st_data   = v.st ? v.data : ~v.data;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = 16'h0;
        got       = 0;
        busy_ok   = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start    = (inject != 0 && n == inject);
            is_store = ~v.st;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                got = n;
                break;
            end
        end
        chk("done_latency", 256'(got), 256'(v.lat));
        chk("busy_while_active", 256'(busy_ok), 256'(1));
        if (!chain) begin
            @(negedge clk);
            chk("idle_after_done", 256'({busy, done, vrf_wr_en, mem_rd, mem_wr}), 256'(0));
            chk("acc_queue_drained", 256'(acc_q.size()), 256'(0));
            chk("vrf_queue_drained", 256'(vrf_q.size()), 256'(0));
        end
        if (v.st) chk("store_ram_image", read_vec(v.base), v.data);
    endtask

    vec_t         tbl[5];
    logic [255:0] d2;
    logic [255:0] exp_img;
    bit           quiet;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[0].data[16*i +: 16] = 16'h1000 + 16'(i);
            tbl[1].data[16*i +: 16] = 16'hA0A0 + 16'(i);
            tbl[2].data[16*i +: 16] = 16'($urandom);
            tbl[3].data[16*i +: 16] = 16'($urandom);
            tbl[4].data[16*i +: 16] = 16'($urandom);
            d2[16*i +: 16]          = 16'h5A00 + 16'(i);
        end
        tbl[0].st = 1'b0; tbl[0].base = 16'h0100; tbl[0].vdst = 3'd3; tbl[0].lat = 18;
        tbl[1].st = 1'b1; tbl[1].base = 16'h0200; tbl[1].vdst = 3'd0; tbl[1].lat = 17;
        tbl[2].st = 1'b0; tbl[2].base = 16'hFFF8; tbl[2].vdst = 3'd5; tbl[2].lat = 18;
        tbl[3].st = 1'b1; tbl[3].base = 16'hFFF4; tbl[3].vdst = 3'd7; tbl[3].lat = 17;
        tbl[4].st = 1'b0; tbl[4].base = 16'h3000; tbl[4].vdst = 3'd6; tbl[4].lat = 18;

        // Reset state, then idle with start low.
        repeat (3) @(negedge clk);
        chk("reset_outputs", 256'({mem_addr, mem_rd, mem_wr, mem_wdata, vrf_wr_en,
                                   vrf_wr_dst, busy, done}), 256'(0));
        chk("reset_vrf_data", vrf_wr_data, 256'(0));
        rst = 1'b1;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy || done || mem_rd || mem_wr || vrf_wr_en) quiet = 1'b0;
        end
        chk("idle_stays_quiet", 256'(quiet), 256'(1));

        // Main table: loads, stores, address wrap in both directions.
        for (int k = 0; k < 4; k++) run_op(tbl[k], 0, 1'b0);

        // Stray start in cycle 5 of a load is ignored; a store launched in
        // the cycle right after the load's DONE is accepted.
        run_op(tbl[4], 5, 1'b1);
        run_op(tbl[1], 0, 1'b0);

        // Reset in cycle 9 of a store: first 8 words land, the rest don't.
        preload(16'h0200, {16{16'hDEAD}});
        for (int i = 0; i < 8; i++)
            acc_q.push_back('{1'b1, 16'h0200 + 16'(i), d2[16*i +: 16]});
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b1; base_addr = 16'h0200; st_data = d2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midop_reset_outputs", 256'({mem_addr, mem_rd, mem_wr, mem_wdata, vrf_wr_en,
                                         vrf_wr_dst, busy, done}), 256'(0));
        chk("midop_reset_vrf_data", vrf_wr_data, 256'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        quiet = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy || done || mem_rd || mem_wr || vrf_wr_en) quiet = 1'b0;
        end
        chk("no_activity_after_abort", 256'(quiet), 256'(1));
        chk("abort_acc_queue_drained", 256'(acc_q.size()), 256'(0));
        exp_img = {{8{16'hDEAD}}, d2[127:0]};
        chk("abort_ram_image", read_vec(16'h0200), exp_img);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
